// File: rtl/hamming_dec_engine_pkg.sv
// Shared types and constants for the SECDED(16,11) decode engine.
// States, status-flag encodings and default memory map.
package hamming_dec_engine_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_LO,
      RD_HI,
      CAP,
      DEC,
      WR_LO,
      WR_HI,
      DONE
   } state_t;

   localparam logic [1:0] FLG_OK  = 2'b00;
   localparam logic [1:0] FLG_SEC = 2'b01;
   localparam logic [1:0] FLG_DED = 2'b10;

   localparam logic [7:0] DEF_SRC_BASE  = 8'd30;
   localparam logic [7:0] DEF_DST_BASE  = 8'd0;
   localparam int         DEF_NUM_WORDS = 15;

   localparam logic [6:0] CNT_MAX = 7'd127;

endpackage

// File: rtl/hamming_dec_engine_if.sv
// Control and data-memory bus of the decode engine.
// The master side is the engine, which owns the memory port while busy.
interface hamming_dec_engine_if;

   logic       start;
   logic       busy;
   logic       done;
   logic [7:0] mem_addr;
   logic       mem_re;
   logic [7:0] mem_rdata;
   logic       mem_we;
   logic [7:0] mem_wdata;
   logic [6:0] single_cnt;
   logic [6:0] double_cnt;

   modport master (
      input  start, mem_rdata,
      output busy, done, mem_addr, mem_re, mem_we, mem_wdata, single_cnt, double_cnt
   );

   modport slave (
      output start, mem_rdata,
      input  busy, done, mem_addr, mem_re, mem_we, mem_wdata, single_cnt, double_cnt
   );

endinterface

// File: rtl/hamming_dec_engine_secded16_dec.sv
// Combinational SECDED decoder for one Hamming(16,11) codeword.
// Bit i of the codeword is Hamming position i; bit 0 is overall parity.
module secded16_dec
   import hamming_dec_engine_pkg::*;
(
   input  logic [15:0] code,
   output logic [10:0] data,
   output logic [1:0]  flags
);

   logic [3:0]  syn;
   logic        par;
   logic [15:0] fixed;

   always_comb begin
      syn   = 4'd0;
      for (int i = 1; i < 16; i++) begin
         if (code[i]) syn = syn ^ 4'(i);
      end
      par   = ^code;
      fixed = code;
      flags = FLG_OK;
      if (syn != 4'd0 && par) begin
         fixed[syn] = ~code[syn];
         flags      = FLG_SEC;
      end else if (syn == 4'd0 && par) begin
         flags = FLG_SEC;
      end else if (syn != 4'd0 && !par) begin
         // Two flips cancel in the parity: leave the data as received.
         flags = FLG_DED;
      end
      data = {fixed[15:9], fixed[7:5], fixed[3]};
   end

endmodule

// File: rtl/hamming_dec_engine.sv
// DMA-style SECDED decoder: reads encoded words from data memory, corrects or
// flags them, and writes 11-bit data plus status flags back, 6 cycles per word.
module hamming_dec_engine
   import hamming_dec_engine_pkg::*;
#(
   parameter logic [7:0] SRC_BASE  = DEF_SRC_BASE,
   parameter logic [7:0] DST_BASE  = DEF_DST_BASE,
   parameter int         NUM_WORDS = DEF_NUM_WORDS
)
(
   input  logic                 clk,
   input  logic                 reset_n,
   hamming_dec_engine_if.master bus
);

   localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

   state_t      state, state_nxt;
   logic [5:0]  index;
   logic [7:0]  word_off, src_addr, dst_addr;
   logic [7:0]  lo_p0, hi_p0;
   logic [10:0] dec_data, data_p1;
   logic [1:0]  dec_flags, flags_p1;
   logic [6:0]  single_cnt, double_cnt;
   logic        last_word;

   function automatic logic [6:0] sat_inc(input logic [6:0] v);
      return (v == CNT_MAX) ? v : v + 7'd1;
   endfunction

   assign word_off  = {1'b0, index, 1'b0};
   assign src_addr  = SRC_BASE + word_off;
   assign dst_addr  = DST_BASE + word_off;
   assign last_word = (index == LAST_IDX);

   secded16_dec u_dec (
      .code  ({hi_p0, lo_p0}),
      .data  (dec_data),
      .flags (dec_flags)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Outputs decode straight from state so reset silences the bus at once.
   always_comb begin
      state_nxt     = state;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.mem_re    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 8'd0;
      bus.mem_wdata = 8'd0;
      case (state)
         IDLE:  if (bus.start) state_nxt = RD_LO;
         RD_LO: begin
            bus.busy = 1'b1; bus.mem_re = 1'b1; bus.mem_addr = src_addr;
            state_nxt = RD_HI;
         end
         RD_HI: begin
            bus.busy = 1'b1; bus.mem_re = 1'b1; bus.mem_addr = src_addr + 8'd1;
            state_nxt = CAP;
         end
         CAP: begin
            bus.busy = 1'b1; state_nxt = DEC;
         end
         DEC: begin
            bus.busy = 1'b1; state_nxt = WR_LO;
         end
         WR_LO: begin
            bus.busy = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = dst_addr;
            bus.mem_wdata = data_p1[7:0];
            state_nxt = WR_HI;
         end
         WR_HI: begin
            bus.busy = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = dst_addr + 8'd1;
            bus.mem_wdata = {flags_p1, 3'b000, data_p1[10:8]};
            state_nxt = last_word ? DONE : RD_LO;
         end
         DONE: begin
            bus.busy = 1'b1; bus.done = 1'b1; state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         index      <= 6'd0;
         single_cnt <= 7'd0;
         double_cnt <= 7'd0;
      end else begin
         if (state == IDLE && bus.start) begin
            index      <= 6'd0;
            single_cnt <= 7'd0;
            double_cnt <= 7'd0;
         end
         if (state == WR_HI && !last_word) index <= index + 6'd1;
         if (state == DEC && dec_flags == FLG_SEC) single_cnt <= sat_inc(single_cnt);
         if (state == DEC && dec_flags == FLG_DED) double_cnt <= sat_inc(double_cnt);
      end
   end

   // p0: codeword capture; read data lags mem_re by one cycle.
   always_ff @(posedge clk) begin
      if (state == RD_HI) lo_p0 <= bus.mem_rdata;
      if (state == CAP)   hi_p0 <= bus.mem_rdata;
   end

   // p1: decoded word held for the two write cycles.
   always_ff @(posedge clk) begin
      if (state == DEC) begin
         data_p1  <= dec_data;
         flags_p1 <= dec_flags;
      end
   end

   assign bus.single_cnt = single_cnt;
   assign bus.double_cnt = double_cnt;

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Directed bench for hamming_dec_engine: single-word cases on a 1-word
// instance, full runs and mid-run reset on a 15-word instance.
module tb_hamming_dec_engine;
   import hamming_dec_engine_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       bd_we, bd_sel;
   logic [7:0] bd_addr, bd_data;
   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   logic [7:0] rd_a, rd_b;
   logic [15:0] exp_word [15];

   int tests_run, tests_failed;

   hamming_dec_engine_if ifa ();
   hamming_dec_engine_if ifb ();

   hamming_dec_engine #(.SRC_BASE(8'd30), .DST_BASE(8'd0), .NUM_WORDS(1)) dut_one (
      .clk(clk), .reset_n(reset_n), .bus(ifa.master));
   hamming_dec_engine #(.SRC_BASE(8'd30), .DST_BASE(8'd0), .NUM_WORDS(15)) dut_full (
      .clk(clk), .reset_n(reset_n), .bus(ifb.master));

   always @(posedge clk) begin
      if (bd_we && !bd_sel) mem_a[bd_addr] <= bd_data;
      else if (ifa.mem_we)  mem_a[ifa.mem_addr] <= ifa.mem_wdata;
      if (ifa.mem_re)       rd_a <= mem_a[ifa.mem_addr];
      if (bd_we && bd_sel)  mem_b[bd_addr] <= bd_data;
      else if (ifb.mem_we)  mem_b[ifb.mem_addr] <= ifb.mem_wdata;
      if (ifb.mem_re)       rd_b <= mem_b[ifb.mem_addr];
   end
   assign ifa.mem_rdata = rd_a;
   assign ifb.mem_rdata = rd_b;

   function automatic logic [15:0] encode(input logic [10:0] d);
      logic [15:0] c;
      logic [3:0]  s;
      c = 16'd0;
      c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3]; c[15:9] = d[10:4];
      s = 4'd0;
      for (int i = 1; i < 16; i++) if (c[i]) s = s ^ 4'(i);
      c[1] = s[0]; c[2] = s[1]; c[4] = s[2]; c[8] = s[3];
      c[0] = ^c[15:1];
      return c;
   endfunction

   task automatic poke(input logic sel, input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      bd_sel = sel; bd_addr = a; bd_data = d; bd_we = 1'b1;
      @(posedge clk); #1 bd_we = 1'b0;
   endtask

   // Loads one codeword into the 1-word instance and runs it; returns done cycle.
   task automatic run_one(input logic [15:0] code, output int dc);
      poke(1'b0, 8'd30, code[7:0]);
      poke(1'b0, 8'd31, code[15:8]);
      poke(1'b0, 8'd0, 8'h5A);
      poke(1'b0, 8'd1, 8'h5A);
      @(negedge clk); ifa.start = 1'b1;
      @(posedge clk); #1 ifa.start = 1'b0;
      dc = -1;
      for (int c = 1; c <= 12; c++) begin
         if (ifa.done === 1'b1 && dc < 0) dc = c;
         @(posedge clk); #1;
      end
   endtask

   task automatic fill_dst_b();
      for (int i = 0; i < 30; i++) poke(1'b1, 8'(i), 8'hEE);
   endtask

   // Full 15-word run on dut_full; an optional stray start lands mid-run.
   task automatic run_full(input string tag, input bit stray);
      int dc, ndone;
      logic [15:0] got;
      fill_dst_b();
      @(negedge clk); ifb.start = 1'b1;
      @(posedge clk); #1 ifb.start = 1'b0;
      dc = -1; ndone = 0;
      for (int c = 1; c <= 110; c++) begin
         if (ifb.done === 1'b1) begin ndone++; if (dc < 0) dc = c; end
         if (stray && c == 20) ifb.start = 1'b1;
         if (c == 21) ifb.start = 1'b0;
         @(posedge clk); #1;
      end
      tests_run++;
      if (dc !== 91) begin tests_failed++; $display("FAIL %s done_cycle: got %0d want 91", tag, dc); end
      tests_run++;
      if (ndone !== 1 || ifb.busy !== 1'b0) begin
         tests_failed++; $display("FAIL %s single_done: done pulses %0d busy %b want 1 and 0", tag, ndone, ifb.busy);
      end
      for (int i = 0; i < 15; i++) begin
         got = {mem_b[2*i+1], mem_b[2*i]};
         tests_run++;
         if (got !== exp_word[i]) begin
            tests_failed++; $display("FAIL %s word%0d: got %h want %h", tag, i, got, exp_word[i]);
         end
      end
      tests_run++;
      if (ifb.single_cnt !== 7'd5 || ifb.double_cnt !== 7'd5) begin
         tests_failed++;
         $display("FAIL %s counters: got %0d/%0d want 5/5", tag, ifb.single_cnt, ifb.double_cnt);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({ifa.busy, ifa.done, ifa.mem_re, ifa.mem_we, ifb.busy, ifb.done, ifb.mem_re, ifb.mem_we} !== 8'h00) begin
         tests_failed++; $display("FAIL reset_ctrl: got %b%b%b%b want 0000", ifb.busy, ifb.done, ifb.mem_re, ifb.mem_we);
      end
      tests_run++;
      if ({ifb.mem_addr, ifb.mem_wdata, ifb.single_cnt, ifb.double_cnt} !== 30'd0) begin
         tests_failed++;
         $display("FAIL reset_data: addr %h wdata %h cnt %0d/%0d want all 0", ifb.mem_addr, ifb.mem_wdata, ifb.single_cnt, ifb.double_cnt);
      end
      @(negedge clk); reset_n = 1'b1;
   endtask

   task automatic test_clean_zero();
      int dc;
      run_one(16'h0000, dc);
      tests_run++;
      if (dc !== 7) begin tests_failed++; $display("FAIL zero_done_cycle: got %0d want 7", dc); end
      tests_run++;
      if ({mem_a[1], mem_a[0]} !== 16'h0000) begin
         tests_failed++; $display("FAIL zero_out: got %h%h want 0000", mem_a[1], mem_a[0]);
      end
      tests_run++;
      if ({ifa.single_cnt, ifa.double_cnt} !== 14'd0) begin
         tests_failed++; $display("FAIL zero_cnt: got %0d/%0d want 0/0", ifa.single_cnt, ifa.double_cnt);
      end
   endtask

   task automatic test_clean_ones();
      int dc;
      run_one(16'hFFFF, dc);
      tests_run++;
      if ({mem_a[1], mem_a[0]} !== 16'h07FF) begin
         tests_failed++; $display("FAIL ones_out: got %h%h want 07FF", mem_a[1], mem_a[0]);
      end
   endtask

   task automatic test_single();
      int dc;
      run_one(16'hFFDF, dc);
      tests_run++;
      if ({mem_a[1], mem_a[0]} !== 16'h47FF) begin
         tests_failed++; $display("FAIL single_out: got %h%h want 47FF", mem_a[1], mem_a[0]);
      end
      tests_run++;
      if (ifa.single_cnt !== 7'd1 || ifa.double_cnt !== 7'd0) begin
         tests_failed++; $display("FAIL single_cnt: got %0d/%0d want 1/0", ifa.single_cnt, ifa.double_cnt);
      end
   endtask

   task automatic test_p0();
      int dc;
      run_one(16'hFFFE, dc);
      tests_run++;
      if ({mem_a[1], mem_a[0]} !== 16'h47FF) begin
         tests_failed++; $display("FAIL p0_out: got %h%h want 47FF", mem_a[1], mem_a[0]);
      end
      tests_run++;
      if (ifa.single_cnt !== 7'd1) begin
         tests_failed++; $display("FAIL p0_cnt: got %0d want 1", ifa.single_cnt);
      end
   endtask

   task automatic test_double();
      int dc;
      run_one(16'hFFD7, dc);
      tests_run++;
      if ({mem_a[1], mem_a[0]} !== 16'h87FC) begin
         tests_failed++; $display("FAIL double_out: got %h%h want 87FC", mem_a[1], mem_a[0]);
      end
      tests_run++;
      if (ifa.double_cnt !== 7'd1 || ifa.single_cnt !== 7'd0) begin
         tests_failed++; $display("FAIL double_cnt: got %0d/%0d want 0/1", ifa.single_cnt, ifa.double_cnt);
      end
   endtask

   task automatic test_full_run();
      logic [10:0] d;
      logic [15:0] c;
      int p1, p2;
      for (int i = 0; i < 15; i++) begin
         d = 11'($urandom_range(0, 2047));
         c = encode(d);
         case (i % 3)
            0: exp_word[i] = {5'b00000, d};
            1: begin
               p1 = $urandom_range(0, 15);
               c[p1] = ~c[p1];
               exp_word[i] = {5'b01000, d};
            end
            default: begin
               p1 = $urandom_range(0, 15);
               p2 = (p1 + $urandom_range(1, 15)) % 16;
               c[p1] = ~c[p1];
               c[p2] = ~c[p2];
               exp_word[i] = {5'b10000, c[15:9], c[7:5], c[3]};
            end
         endcase
         poke(1'b1, 8'(30 + 2*i), c[7:0]);
         poke(1'b1, 8'(31 + 2*i), c[15:8]);
      end
      run_full("full", 1'b1);
   endtask

   task automatic test_reset_midrun();
      fill_dst_b();
      @(negedge clk); ifb.start = 1'b1;
      @(posedge clk); #1 ifb.start = 1'b0;
      for (int c = 1; c < 23; c++) begin
         @(posedge clk); #1;
      end
      tests_run++;
      if (ifb.mem_we !== 1'b1 || ifb.mem_addr !== 8'd6) begin
         tests_failed++; $display("FAIL midrun_wr_lo: we %b addr %0d want 1 and 6", ifb.mem_we, ifb.mem_addr);
      end
      #2 reset_n = 1'b0;
      #1;
      tests_run++;
      if (ifb.mem_we !== 1'b0 || ifb.busy !== 1'b0) begin
         tests_failed++; $display("FAIL midrun_drop: we %b busy %b want 0 0", ifb.mem_we, ifb.busy);
      end
      tests_run++;
      if (ifb.single_cnt !== 7'd0 || ifb.double_cnt !== 7'd0) begin
         tests_failed++; $display("FAIL midrun_cnt: got %0d/%0d want 0/0", ifb.single_cnt, ifb.double_cnt);
      end
      @(posedge clk); #1;
      tests_run++;
      if (mem_b[6] !== 8'hEE) begin
         tests_failed++; $display("FAIL midrun_nowrite: got %h want EE", mem_b[6]);
      end
      @(negedge clk); reset_n = 1'b1;
      run_full("rerun", 1'b0);
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      ifa.start = 1'b0; ifb.start = 1'b0;
      bd_we = 1'b0; bd_sel = 1'b0; bd_addr = 8'd0; bd_data = 8'd0;
      reset_n = 1'b1;
      #3 reset_n = 1'b0;
      test_reset();
      test_clean_zero();
      test_clean_ones();
      test_single();
      test_p0();
      test_double();
      test_full_run();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
